// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in/serial-out transmitter.
package piso_pkg;

    localparam int unsigned PISO_WIDTH        = 8;
    localparam int unsigned PISO_CLKS_PER_BIT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/piso_bit_timer.sv
// Bit-time divider: counts CLKS_PER_BIT cycles per serial bit and flags the first and last cycle.
module piso_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_start,
    output logic bit_end
);

    localparam int unsigned DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

    logic [DW-1:0] div_cnt;

    // Flags are decoded from the registered count, gated by the registered enable.
    assign bit_start = enable && (div_cnt == '0);
    assign bit_end   = enable && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
        end else if (enable) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on a valid/ready handshake and sends it MSB-first.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH        = PISO_WIDTH,
    parameter int unsigned CLKS_PER_BIT = PISO_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             bit_start,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic             accept_c;
    logic             shifting_c;
    logic             tick_start;
    logic             tick_end;

    assign accept_c   = (state == IDLE) && load_valid;
    assign shifting_c = (state == SHIFT);

    piso_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept_c),
        .enable   (shifting_c),
        .bit_start(tick_start),
        .bit_end  (tick_end)
    );

    // Control FSM with shift register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shreg   <= din;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick_end) begin
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches an output.
    assign load_ready = (state == IDLE);
    assign sdo        = shifting_c && shreg[WIDTH-1];
    assign sdo_valid  = shifting_c;
    assign bit_start  = tick_start;
    assign busy       = (state == SHIFT) || (state == DONE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx in three parameterisations.
module tb_piso_tx;

    logic clk;
    logic rst_n;

    logic       lv1, lr1, sdo1, sv1, bs1, busy1, done1;
    logic [7:0] din1;
    logic       lv4, lr4, sdo4, sv4, bs4, busy4, done4;
    logic [7:0] din4;
    logic       lvw, lrw, sdow, svw, bsw, busyw, donew;
    logic [3:0] dinw;

    int n_cmp = 0;
    int n_err = 0;

    piso_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_ready(lr1), .din(din1),
        .sdo(sdo1), .sdo_valid(sv1), .bit_start(bs1), .busy(busy1), .done(done1)
    );

    piso_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv4), .load_ready(lr4), .din(din4),
        .sdo(sdo4), .sdo_valid(sv4), .bit_start(bs4), .busy(busy4), .done(done4)
    );

    piso_tx #(.WIDTH(4), .CLKS_PER_BIT(2)) u_dutw (
        .clk(clk), .rst_n(rst_n), .load_valid(lvw), .load_ready(lrw), .din(dinw),
        .sdo(sdow), .sdo_valid(svw), .bit_start(bsw), .busy(busyw), .done(donew)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] seq_w;

        rst_n = 1'b0;
        lv1 = 1'b0; din1 = '0;
        lv4 = 1'b0; din4 = '0;
        lvw = 1'b0; dinw = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Reset state
        check("rst lr1", 32'(lr1), 32'd1);
        check("rst sdo1", 32'(sdo1), 32'd0);
        check("rst sv1", 32'(sv1), 32'd0);
        check("rst bs1", 32'(bs1), 32'd0);
        check("rst busy1", 32'(busy1), 32'd0);
        check("rst done1", 32'(done1), 32'd0);
        check("rst lr4", 32'(lr4), 32'd1);
        check("rst lrw", 32'(lrw), 32'd1);

        // Basic transfer, 8'hA5, one clock per bit
        pat  = 8'b1010_0101;
        din1 = 8'hA5;
        lv1  = 1'b1;
        cyc();
        lv1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("basic sdo c%0d", c), 32'(sdo1), 32'(pat[8-c]));
            check($sformatf("basic sv c%0d", c), 32'(sv1), 32'd1);
            check($sformatf("basic bs c%0d", c), 32'(bs1), 32'd1);
            check($sformatf("basic busy c%0d", c), 32'(busy1), 32'd1);
            check($sformatf("basic lr c%0d", c), 32'(lr1), 32'd0);
            check($sformatf("basic done c%0d", c), 32'(done1), 32'd0);
            cyc();
        end
        check("basic done c9", 32'(done1), 32'd1);
        check("basic sv c9", 32'(sv1), 32'd0);
        check("basic sdo c9", 32'(sdo1), 32'd0);
        check("basic busy c9", 32'(busy1), 32'd1);
        check("basic lr c9", 32'(lr1), 32'd0);
        cyc();
        check("basic lr c10", 32'(lr1), 32'd1);
        check("basic done c10", 32'(done1), 32'd0);
        check("basic busy c10", 32'(busy1), 32'd0);

        // Slow bit time, 8'h81, four clocks per bit
        din4 = 8'h81;
        lv4  = 1'b1;
        cyc();
        lv4 = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            check($sformatf("slow sdo c%0d", c), 32'(sdo4), ((c <= 4) || (c >= 29)) ? 32'd1 : 32'd0);
            check($sformatf("slow bs c%0d", c), 32'(bs4), (((c - 1) % 4) == 0) ? 32'd1 : 32'd0);
            check($sformatf("slow sv c%0d", c), 32'(sv4), 32'd1);
            check($sformatf("slow done c%0d", c), 32'(done4), 32'd0);
            cyc();
        end
        check("slow done c33", 32'(done4), 32'd1);
        check("slow sv c33", 32'(sv4), 32'd0);
        cyc();
        check("slow lr c34", 32'(lr4), 32'd1);
        check("slow done c34", 32'(done4), 32'd0);

        // Back-to-back: valid held high, din switches to 00 in cycle 3
        din1 = 8'hFF;
        lv1  = 1'b1;
        cyc();
        for (int c = 1; c <= 18; c++) begin
            if (c == 3) din1 = 8'h00;
            if (c <= 8) begin
                check($sformatf("b2b sdo c%0d", c), 32'(sdo1), 32'd1);
                check($sformatf("b2b sv c%0d", c), 32'(sv1), 32'd1);
            end else if (c == 9) begin
                check("b2b done c9", 32'(done1), 32'd1);
                check("b2b sv c9", 32'(sv1), 32'd0);
            end else if (c == 10) begin
                check("b2b lr c10", 32'(lr1), 32'd1);
                check("b2b done c10", 32'(done1), 32'd0);
                check("b2b sv c10", 32'(sv1), 32'd0);
            end else begin
                check($sformatf("b2b sdo c%0d", c), 32'(sdo1), 32'd0);
                check($sformatf("b2b sv c%0d", c), 32'(sv1), 32'd1);
                check($sformatf("b2b done c%0d", c), 32'(done1), 32'd0);
            end
            cyc();
        end
        check("b2b done c19", 32'(done1), 32'd1);
        lv1 = 1'b0;
        cyc();
        check("b2b lr c20", 32'(lr1), 32'd1);
        check("b2b done c20", 32'(done1), 32'd0);
        cyc();
        check("b2b sv c21", 32'(sv1), 32'd0);
        check("b2b lr c21", 32'(lr1), 32'd1);

        // Busy ignore: valid pulse with 8'h3C during cycle 3 of an 8'h96 word
        pat  = 8'b1001_0110;
        din1 = 8'h96;
        lv1  = 1'b1;
        cyc();
        lv1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) begin
                lv1  = 1'b1;
                din1 = 8'h3C;
            end
            if (c == 4) lv1 = 1'b0;
            check($sformatf("ign sdo c%0d", c), 32'(sdo1), 32'(pat[8-c]));
            check($sformatf("ign lr c%0d", c), 32'(lr1), 32'd0);
            cyc();
        end
        check("ign done c9", 32'(done1), 32'd1);
        check("ign lr c9", 32'(lr1), 32'd0);
        cyc();
        check("ign lr c10", 32'(lr1), 32'd1);
        cyc();
        check("ign sv c11", 32'(sv1), 32'd0);
        check("ign busy c11", 32'(busy1), 32'd0);

        // Reset asserted asynchronously in cycle 4 of an 8'hA5 transfer
        din1 = 8'hA5;
        lv1  = 1'b1;
        cyc();
        lv1 = 1'b0;
        cyc();
        cyc();
        cyc();
        check("mrst sv c4", 32'(sv1), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst sdo", 32'(sdo1), 32'd0);
        check("mrst sv", 32'(sv1), 32'd0);
        check("mrst bs", 32'(bs1), 32'd0);
        check("mrst busy", 32'(busy1), 32'd0);
        check("mrst done", 32'(done1), 32'd0);
        check("mrst lr", 32'(lr1), 32'd1);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            check($sformatf("mrst idle done %0d", c), 32'(done1), 32'd0);
            check($sformatf("mrst idle sv %0d", c), 32'(sv1), 32'd0);
        end
        pat  = 8'b0101_1010;
        din1 = 8'h5A;
        lv1  = 1'b1;
        cyc();
        lv1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("post sdo c%0d", c), 32'(sdo1), 32'(pat[8-c]));
            check($sformatf("post sv c%0d", c), 32'(sv1), 32'd1);
            cyc();
        end
        check("post done c9", 32'(done1), 32'd1);

        // Width sweep: 4-bit word 1001, two clocks per bit
        seq_w = 8'b1100_0011;
        dinw  = 4'b1001;
        lvw   = 1'b1;
        cyc();
        lvw = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("wsw sdo c%0d", c), 32'(sdow), 32'(seq_w[8-c]));
            check($sformatf("wsw sv c%0d", c), 32'(svw), 32'd1);
            check($sformatf("wsw bs c%0d", c), 32'(bsw), ((c % 2) == 1) ? 32'd1 : 32'd0);
            check($sformatf("wsw done c%0d", c), 32'(donew), 32'd0);
            cyc();
        end
        check("wsw done c9", 32'(donew), 32'd1);
        check("wsw sv c9", 32'(svw), 32'd0);
        cyc();
        check("wsw lr c10", 32'(lrw), 32'd1);
        check("wsw done c10", 32'(donew), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
